codebreaker_led_out: RTL and testbench

CODEBREAKER_LED_OUT -- requirements
Module: codebreaker_led_out

---
 rtl/codebreaker_led_out_if.sv | 19 +
 rtl/codebreaker_led_out.sv | 93 +++++++++
 tb/tb_codebreaker_led_out.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/codebreaker_led_out_if.sv
// Avalon-MM slave bus for the LED output block; the master drives address and write strobes.
// readdata is produced by the slave one cycle after the address is presented.
interface codebreaker_led_out_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/codebreaker_led_out.sv
// LED output register bank with set/clear ports and a masked blinker; reads have 1-cycle latency.
// Writes are always accepted in the cycle they are presented; there is no backpressure.
module codebreaker_led_out #(
    parameter int unsigned       WIDTH        = 10,
    parameter logic [WIDTH-1:0]  RESET_VALUE  = '0,
    parameter logic [23:0]       RESET_PERIOD = '0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    codebreaker_led_out_if.slave     bus,
    output logic [WIDTH-1:0]         out_port
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [23:0]      period_q, period_d;
    logic [23:0]      cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic [31:0]      readdata_q, readdata_d;

    logic             wr;
    logic [WIDTH-1:0] wd_lo;
    logic             unused_wd;

    assign wr        = bus.chipselect && !bus.write_n;
    assign wd_lo     = bus.writedata[WIDTH-1:0];
    assign unused_wd = ^bus.writedata;

    always_comb begin
        data_d     = data_q;
        mask_d     = mask_q;
        period_d   = period_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        readdata_d = 32'd0;

        if (wr) begin
            case (bus.address)
                3'd0:    data_d   = wd_lo;
                3'd1:    mask_d   = wd_lo;
                3'd2:    period_d = bus.writedata[23:0];
                3'd4:    data_d   = data_q | wd_lo;
                3'd5:    data_d   = data_q & ~wd_lo;
                default: ;
            endcase
        end

        // A period write restarts the blink so a shorter period can never be overrun.
        if (wr && bus.address == 3'd2) begin
            cnt_d   = 24'd0;
            phase_d = 1'b1;
        end else if (period_q == 24'd0) begin
            cnt_d   = 24'd0;
            phase_d = 1'b1;
        end else if (cnt_q == period_q - 24'd1) begin
            cnt_d   = 24'd0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + 24'd1;
        end

        // Read mux uses pre-edge register values; same-cycle writes are not bypassed.
        case (bus.address)
            3'd0:    readdata_d = 32'(data_q);
            3'd1:    readdata_d = 32'(mask_q);
            3'd2:    readdata_d = {8'd0, period_q};
            3'd3:    readdata_d = {31'd0, phase_q};
            default: readdata_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= RESET_VALUE;
            mask_q     <= '0;
            period_q   <= RESET_PERIOD;
            cnt_q      <= 24'd0;
            phase_q    <= 1'b1;
            readdata_q <= 32'd0;
        end else begin
            data_q     <= data_d;
            mask_q     <= mask_d;
            period_q   <= period_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            readdata_q <= readdata_d;
        end
    end

    assign out_port     = data_q & ~(mask_q & {WIDTH{~phase_q}});
    assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_codebreaker_led_out.sv
// Randomised and directed bench for codebreaker_led_out against an elapsed-time blink model.
module tb_codebreaker_led_out;
    localparam int unsigned      W  = 10;
    localparam logic [W-1:0]     RV = '0;
    localparam logic [23:0]      RP = '0;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] out_port;

    codebreaker_led_out_if bus();

    codebreaker_led_out #(.WIDTH(W), .RESET_VALUE(RV), .RESET_PERIOD(RP)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .out_port(out_port)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: register contents plus edges elapsed since the last period restart.
    logic [W-1:0] m_data, m_mask;
    logic [23:0]  m_period;
    int unsigned  m_elapsed;
    logic [31:0]  m_rd;

    function automatic logic m_phase();
        if (m_period == 24'd0) return 1'b1;
        return ((m_elapsed / m_period) % 2) == 0;
    endfunction

    function automatic logic [W-1:0] m_out();
        return m_data & ~(m_mask & {W{~m_phase()}});
    endfunction

    function automatic void m_reset();
        m_data = RV; m_mask = '0; m_period = RP; m_elapsed = 0; m_rd = 32'd0;
    endfunction

    task automatic cycle(input logic [2:0] a, input logic cs, input logic wn, input logic [31:0] wd);
        @(negedge clk);
        bus.address = a; bus.chipselect = cs; bus.write_n = wn; bus.writedata = wd;
        case (a)
            3'd0:    m_rd = 32'(m_data);
            3'd1:    m_rd = 32'(m_mask);
            3'd2:    m_rd = {8'd0, m_period};
            3'd3:    m_rd = {31'd0, m_phase()};
            default: m_rd = 32'd0;
        endcase
        if (cs && !wn) begin
            case (a)
                3'd0:    m_data   = wd[W-1:0];
                3'd1:    m_mask   = wd[W-1:0];
                3'd2:    m_period = wd[23:0];
                3'd4:    m_data   = m_data | wd[W-1:0];
                3'd5:    m_data   = m_data & ~wd[W-1:0];
                default: ;
            endcase
        end
        if (cs && !wn && a == 3'd2) m_elapsed = 0;
        else m_elapsed++;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] wd);
        cycle(a, 1'b1, 1'b0, wd);
    endtask

    task automatic idle(input logic [2:0] a);
        cycle(a, 1'b0, 1'b1, 32'd0);
    endtask

    task automatic test_reset();
        bus.address = 3'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'd0;
        reset_n = 1'b0;
        m_reset();
        #22;
        checks++; if (out_port !== RV) begin errors++; $display("FAIL reset_out: got %h expected %h", out_port, RV); end
        checks++; if (bus.readdata !== 32'd0) begin errors++; $display("FAIL reset_rd: got %h expected 0", bus.readdata); end
        @(negedge clk) reset_n = 1'b1;
        idle(3'd0);
        checks++; if (bus.readdata !== 32'h000) begin errors++; $display("FAIL reset_rd_data: got %h expected 000", bus.readdata); end
        idle(3'd3);
        checks++; if (bus.readdata !== 32'h1) begin errors++; $display("FAIL reset_rd_status: got %h expected 1", bus.readdata); end
        checks++; if (out_port !== 10'h000) begin errors++; $display("FAIL reset_out2: got %h expected 000", out_port); end
    endtask

    task automatic test_data_ops();
        wr(3'd0, 32'hFFFF_F2A5);
        checks++; if (out_port !== 10'h2A5) begin errors++; $display("FAIL data_write: got %h expected 2a5", out_port); end
        wr(3'd4, 32'h0000_000F);
        checks++; if (out_port !== 10'h2AF) begin errors++; $display("FAIL outset: got %h expected 2af", out_port); end
        wr(3'd5, 32'hA500_0201);
        checks++; if (out_port !== 10'h0AE) begin errors++; $display("FAIL outclear: got %h expected 0ae", out_port); end
        idle(3'd0);
        checks++; if (bus.readdata !== 32'h0AE) begin errors++; $display("FAIL data_read: got %h expected 0ae", bus.readdata); end
    endtask

    task automatic test_blink();
        logic [W-1:0] lit;
        wr(3'd0, 32'h3FF);
        wr(3'd1, 32'h00F);
        wr(3'd2, 32'h3);
        for (int i = 0; i < 12; i++) begin
            idle(3'd3);
            lit = (((i + 1) / 3) % 2 == 0) ? 10'h3FF : 10'h3F0;
            checks++; if (out_port !== lit) begin errors++; $display("FAIL blink_out[%0d]: got %h expected %h", i, out_port, lit); end
            checks++; if (bus.readdata !== {31'd0, ((i / 3) % 2 == 0)}) begin errors++; $display("FAIL blink_status[%0d]: got %h expected %0d", i, bus.readdata, ((i / 3) % 2 == 0)); end
        end
    endtask

    task automatic test_period_restart();
        wr(3'd2, 32'd100);
        repeat (5) idle(3'd3);
        wr(3'd2, 32'd2);
        checks++; if (out_port !== 10'h3FF) begin errors++; $display("FAIL restart_phase: got %h expected 3ff", out_port); end
        idle(3'd2);
        checks++; if (out_port !== 10'h3FF) begin errors++; $display("FAIL restart_k1: got %h expected 3ff", out_port); end
        checks++; if (bus.readdata !== 32'd2) begin errors++; $display("FAIL restart_period_rd: got %h expected 2", bus.readdata); end
        idle(3'd3);
        checks++; if (out_port !== 10'h3F0) begin errors++; $display("FAIL restart_k2: got %h expected 3f0", out_port); end
        wr(3'd2, 32'd0);
        for (int i = 0; i < 10; i++) begin
            idle(3'd3);
            checks++; if (out_port !== m_data || bus.readdata !== 32'd1) begin
                errors++; $display("FAIL period0_hold[%0d]: got out=%h rd=%h expected out=%h rd=1", i, out_port, bus.readdata, m_data);
            end
        end
    endtask

    task automatic test_ignored();
        logic [W-1:0] s_data, s_mask;
        s_data = m_data; s_mask = m_mask;
        cycle(3'd0, 1'b0, 1'b0, 32'h155);
        wr(3'd6, 32'hFFFF_FFFF);
        wr(3'd3, 32'hFFFF_FFFF);
        wr(3'd7, 32'hFFFF_FFFF);
        checks++; if (out_port !== s_data) begin errors++; $display("FAIL ignored_out: got %h expected %h", out_port, s_data); end
        for (int a = 4; a < 8; a++) begin
            idle(3'(a));
            checks++; if (bus.readdata !== 32'd0) begin errors++; $display("FAIL read_hole[%0d]: got %h expected 0", a, bus.readdata); end
        end
        idle(3'd0);
        checks++; if (bus.readdata !== 32'(s_data)) begin errors++; $display("FAIL ignored_data: got %h expected %h", bus.readdata, s_data); end
        idle(3'd1);
        checks++; if (bus.readdata !== 32'(s_mask)) begin errors++; $display("FAIL ignored_mask: got %h expected %h", bus.readdata, s_mask); end
    endtask

    task automatic test_random();
        logic [2:0]  a;
        logic [31:0] wd;
        for (int i = 0; i < 400; i++) begin
            a  = 3'($urandom_range(0, 7));
            wd = $urandom;
            if (a == 3'd2) wd[23:0] = 24'($urandom_range(0, 5));
            cycle(a, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 0, wd);
            checks++; if (out_port !== m_out()) begin errors++; $display("FAIL rand_out[%0d]: got %h expected %h", i, out_port, m_out()); end
            checks++; if (bus.readdata !== m_rd) begin errors++; $display("FAIL rand_rd[%0d]: got %h expected %h", i, bus.readdata, m_rd); end
        end
    endtask

    task automatic test_async_reset();
        int n;
        wr(3'd0, 32'h155);
        wr(3'd1, 32'h3FF);
        wr(3'd2, 32'd2);
        n = 0;
        while (m_phase() && n < 10) begin idle(3'd1); n++; end
        checks++; if (out_port !== 10'h000 || m_phase()) begin errors++; $display("FAIL areset_setup: got %h expected 000", out_port); end
        #2 reset_n = 1'b0;
        m_reset();
        #1;
        checks++; if (out_port !== RV) begin errors++; $display("FAIL areset_out: got %h expected %h", out_port, RV); end
        checks++; if (bus.readdata !== 32'd0) begin errors++; $display("FAIL areset_rd: got %h expected 0", bus.readdata); end
        @(negedge clk) reset_n = 1'b1;
        idle(3'd1);
        checks++; if (bus.readdata !== 32'd0) begin errors++; $display("FAIL areset_mask: got %h expected 0", bus.readdata); end
        idle(3'd3);
        checks++; if (bus.readdata !== 32'd1) begin errors++; $display("FAIL areset_phase: got %h expected 1", bus.readdata); end
    endtask

    initial begin
        test_reset();
        test_data_ops();
        test_blink();
        test_period_restart();
        test_ignored();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
